// File: rtl/avalon_ram_agent_pkg.sv
// Shared types and bus widths for the Avalon-MM word RAM agent.
package avalon_ram_agent_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        IDLE,
        WRITE_WAIT
    } agent_wr_state_t;

endpackage

// File: rtl/avalon_ram_agent_if.sv
// Avalon-MM read/write bus between a host (master) and the RAM agent (slave).
interface avalon_ram_agent_if;
    import avalon_ram_agent_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] host_to_agent;
    logic [DATA_W-1:0] agent_to_host;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, read, write, byteenable, host_to_agent,
        input  agent_to_host, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, host_to_agent,
        output agent_to_host, waitrequest, readdatavalid
    );

endinterface

// File: rtl/avalon_ram_agent_rdl.sv
// Read delay line: fixed-latency valid/data shift register for read responses.
module avalon_ram_agent_rdl
    import avalon_ram_agent_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              readdatavalid,
    output logic [DATA_W-1:0] agent_to_host,
    output logic              retire
);

    logic [READ_LATENCY-1:0] vld_p;
    logic [DATA_W-1:0]       data_p [READ_LATENCY];

    // Data is zero-filled on empty slots and cleared on reset so the bus reads 0 whenever no response is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) data_p[i] <= '0;
        end else begin
            vld_p[0]  <= load;
            data_p[0] <= load ? load_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign readdatavalid = vld_p[READ_LATENCY-1];
    assign agent_to_host = data_p[READ_LATENCY-1];
    assign retire        = vld_p[READ_LATENCY-1];

endmodule

// File: rtl/avalon_ram_agent.sv
// Word-organised RAM agent: pipelined fixed-latency reads, byte-masked writes with wait states.
module avalon_ram_agent
    import avalon_ram_agent_pkg::*;
#(
    parameter int    WORDS             = 1024,
    parameter int    READ_LATENCY      = 2,
    parameter int    MAX_PENDING       = 2,
    parameter int    WRITE_WAIT_STATES = 0,
    parameter string INIT_FILE         = ""
) (
    input  logic               clk,
    input  logic               rst,
    avalon_ram_agent_if.slave  port,
    output logic               protocol_error
);

    localparam int IDX_W = $clog2(WORDS);
    localparam int PND_W = $clog2(MAX_PENDING + 1);

    logic [DATA_W-1:0] mem [WORDS];

    logic [IDX_W-1:0]  idx;
    logic              addr_unused;
    logic [PND_W-1:0]  pending;
    logic              retire;
    logic              rd_full;
    logic              rd_accept;
    logic              wr_commit;
    logic              wr_abort;
    logic              waitrequest;
    agent_wr_state_t   state, state_nx;
    logic [3:0]        wait_cnt, wait_cnt_nx;
    logic              rdv;
    logic [DATA_W-1:0] rdata;

    assign idx         = port.address[IDX_W+1:2];
    assign addr_unused = ^{port.address[ADDR_W-1:IDX_W+2], port.address[1:0]};

    // A retiring response frees its slot in the same cycle, so a full line can still accept.
    assign rd_full = (pending == PND_W'(MAX_PENDING)) && !retire;

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        waitrequest = 1'b0;
        rd_accept   = 1'b0;
        wr_commit   = 1'b0;
        wr_abort    = 1'b0;
        case (state)
            IDLE: begin
                if (port.write) begin
                    // Writes hold off until every outstanding read has returned.
                    if (pending != '0) begin
                        waitrequest = 1'b1;
                    end else if (WRITE_WAIT_STATES == 0) begin
                        wr_commit = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        wait_cnt_nx = 4'(WRITE_WAIT_STATES - 1);
                        state_nx    = WRITE_WAIT;
                    end
                end else if (port.read) begin
                    waitrequest = rd_full;
                    rd_accept   = !rd_full;
                end
            end
            WRITE_WAIT: begin
                if (!port.write) begin
                    waitrequest = 1'b1;
                    wr_abort    = 1'b1;
                    state_nx    = IDLE;
                end else if (wait_cnt != 4'd0) begin
                    waitrequest = 1'b1;
                    wait_cnt_nx = wait_cnt - 4'd1;
                end else begin
                    wr_commit = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending + PND_W'(rd_accept) - PND_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_error <= 1'b0;
        end else if (wr_abort || (port.read && port.write)) begin
            protocol_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && !rst) begin
            for (int i = 0; i < BE_W; i++) begin
                if (port.byteenable[i]) mem[idx][8*i +: 8] <= port.host_to_agent[8*i +: 8];
            end
        end
    end

    avalon_ram_agent_rdl #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rdl (
        .clk           (clk),
        .rst           (rst),
        .load          (rd_accept),
        .load_data     (mem[idx]),
        .readdatavalid (rdv),
        .agent_to_host (rdata),
        .retire        (retire)
    );

    assign port.waitrequest   = waitrequest;
    assign port.readdatavalid = rdv;
    assign port.agent_to_host = rdata;

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Scoreboard bench for avalon_ram_agent: two parameterisations driven by directed vectors.
module tb_avalon_ram_agent;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic perr_a, perr_b;

    avalon_ram_agent_if ia ();
    avalon_ram_agent_if ib ();

    avalon_ram_agent #(
        .WORDS(1024), .READ_LATENCY(2), .MAX_PENDING(2), .WRITE_WAIT_STATES(2), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .rst(rst_a), .port(ia.slave), .protocol_error(perr_a)
    );

    avalon_ram_agent #(
        .WORDS(1024), .READ_LATENCY(3), .MAX_PENDING(1), .WRITE_WAIT_STATES(0), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .rst(rst_b), .port(ib.slave), .protocol_error(perr_b)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdv_a_cnt = 0;
    int   w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitors: pop the oldest expectation whenever a response appears.
    always @(negedge clk) begin
        if (ia.readdatavalid === 1'b1) begin
            rdv_a_cnt++;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rdv: got data %h expected no response", ia.agent_to_host);
            end else begin
                ea = qa.pop_front();
                check("a_rdata", ia.agent_to_host, ea.data);
                check("a_rcycle", cyc, ea.cyc);
            end
        end else if (ia.agent_to_host !== 32'h0 && !$isunknown(ia.readdatavalid)) begin
            checks++;
            errors++;
            $display("FAIL a_idle_data: got %h expected 00000000", ia.agent_to_host);
        end
        if (ib.readdatavalid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rdv: got data %h expected no response", ib.agent_to_host);
            end else begin
                eb = qb.pop_front();
                check("b_rdata", ib.agent_to_host, eb.data);
                check("b_rcycle", cyc, eb.cyc);
            end
        end
    end

    task automatic bus(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
        if (sel) begin
            ib.read = rd; ib.write = wr; ib.address = addr; ib.host_to_agent = data; ib.byteenable = be;
        end else begin
            ia.read = rd; ia.write = wr; ia.address = addr; ia.host_to_agent = data; ia.byteenable = be;
        end
    endtask

    function automatic logic wreq(input bit sel);
        return sel ? ib.waitrequest : ia.waitrequest;
    endfunction

    // Called at a falling edge; holds the request until accepted, returns at the next falling edge.
    task automatic xfer(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input bit push,
                        input logic [31:0] exp_d, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        bus(sel, rd, wr, addr, data, be);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (wreq(sel) === 1'b0) begin
                done = 1'b1;
                if (push) begin
                    if (sel) qb.push_back(exp_t'{exp_d, cyc + 3});
                    else     qa.push_back(exp_t'{exp_d, cyc + 2});
                end
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got waitrequest stuck at addr %h expected acceptance", addr);
        end
        @(negedge clk);
        bus(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("a_rst_wreq", ia.waitrequest, 1'b0);
        check("a_rst_perr", perr_a, 1'b0);
        check("b_rst_rdv", ib.readdatavalid, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Fill dut_a: word k = k for k = 0..2, plus two other words
        xfer(1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 4'hF, 1'b0, 32'h0, w);
        check("a_wr_waits", w, 2);
        xfer(1'b0, 1'b0, 1'b1, 32'h04, 32'h1, 4'hF, 1'b0, 32'h0, w);
        xfer(1'b0, 1'b0, 1'b1, 32'h08, 32'h2, 4'hF, 1'b0, 32'h0, w);
        xfer(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, w);
        xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0, w);

        // Back-to-back reads
        xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, w);
        check("a_b2b_wait0", w, 0);
        xfer(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h1, w);
        check("a_b2b_wait1", w, 0);
        xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h2, w);
        check("a_b2b_wait2", w, 0);
        repeat (4) @(negedge clk);

        // Byte-masked write with wait states, plus an address alias read (upper bits ignored)
        check("a_perr_clear", perr_a, 1'b0);
        xfer(1'b0, 1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, w);
        check("a_mask_waits", w, 2);
        xfer(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h00BB00DD, w);
        xfer(1'b0, 1'b1, 1'b0, 32'h0000_1013, 32'h0, 4'h0, 1'b1, 32'h00BB00DD, w);
        repeat (4) @(negedge clk);

        // Write dropped mid-wait
        bus(1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
        #1;
        check("a_abort_wreq", ia.waitrequest, 1'b1);
        @(negedge clk);
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("a_perr_abort", perr_a, 1'b1);
        xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h2, w);
        repeat (4) @(negedge clk);

        // read && write together: handled as a write only
        xfer(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, w);
        check("a_rw_waits", w, 2);
        check("a_perr_sticky", perr_a, 1'b1);
        xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, w);
        repeat (4) @(negedge clk);

        // Reset held 3 cycles with read high; first read accepted right after release
        bus(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_rstr_rdv", ia.readdatavalid, 1'b0);
            check("a_rstr_data", ia.agent_to_host, 32'h0);
            check("a_rstr_perr", perr_a, 1'b0);
        end
        rst_a = 1'b0;
        #1;
        check("a_rstr_accept", ia.waitrequest, 1'b0);
        qa.push_back(exp_t'{32'h1, cyc + 2});
        @(negedge clk);
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) @(negedge clk);

        // Reset one cycle after a read is accepted: no response may follow
        rdv_a_cnt = 0;
        xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, w);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        check("a_rst_midread", rdv_a_cnt, 0);

        // dut_b: zero-wait writes, then the outstanding-read limit
        xfer(1'b1, 1'b0, 1'b1, 32'h14, 32'h55, 4'hF, 1'b0, 32'h0, w);
        check("b_wr_waits", w, 0);
        xfer(1'b1, 1'b0, 1'b1, 32'h18, 32'h66, 4'hF, 1'b0, 32'h0, w);
        bus(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        #1;
        check("b_first_accept", ib.waitrequest, 1'b0);
        qb.push_back(exp_t'{32'h55, cyc + 3});
        @(negedge clk);
        xfer(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b1, 32'h66, w);
        check("b_stall_cycles", w, 2);
        repeat (6) @(negedge clk);

        // dut_b: read && write with no wait states
        check("b_perr_clear", perr_b, 1'b0);
        xfer(1'b1, 1'b1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, w);
        check("b_rw_waits", w, 0);
        check("b_perr_set", perr_b, 1'b1);
        xfer(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0BADF00D, w);
        repeat (8) @(negedge clk);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
